// File: rtl/store_buffered_dmem_pkg.sv
// Shared types and default sizes for the store-buffered data memory.
// Entry layout, drain FSM states and default N/AW/DEPTH/WLAT.
package dmem_pkg;

  localparam int DEF_N     = 64;
  localparam int DEF_AW    = 6;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_WLAT  = 2;

  typedef struct packed {
    logic [DEF_AW-1:0] idx;
    logic [DEF_N-1:0]  data;
  } sb_entry_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_t;

endpackage

// File: rtl/store_buffered_dmem_if.sv
// DM_* port between the MEM stage (master) and the data memory (slave).
// Carries addr/data/enables, combinational read data and buffer status.
interface store_buffered_dmem_if
  import dmem_pkg::*;
#(
  parameter int N = DEF_N
);

  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
  logic         DM_writeEnable;
  logic         DM_readEnable;
  logic [N-1:0] DM_readData;
  logic         sb_empty;
  logic         sb_full;
  logic         sb_overflow;

  modport master (
    output DM_addr,
    output DM_writeData,
    output DM_writeEnable,
    output DM_readEnable,
    input  DM_readData,
    input  sb_empty,
    input  sb_full,
    input  sb_overflow
  );

  modport slave (
    input  DM_addr,
    input  DM_writeData,
    input  DM_writeEnable,
    input  DM_readEnable,
    output DM_readData,
    output sb_empty,
    output sb_full,
    output sb_overflow
  );

endinterface

// File: rtl/store_buffered_dmem_sb_fifo.sv
// Store buffer FIFO: push/pop, head entry, youngest-match lookup.
// Ports: clk, reset, push/push_entry, pop, head, empty, full, occ, look_*.
module sb_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  sb_entry_t         push_entry,
  input  logic              pop,
  output sb_entry_t         head,
  output logic              empty,
  output logic              full,
  output logic [$clog2(DEPTH):0] occ,
  input  logic [DEF_AW-1:0] look_idx,
  output logic              hit,
  output logic [DEF_N-1:0]  hit_data
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t     ent [DEPTH];
  logic [PW-1:0] hd;
  logic [PW-1:0] tl;
  logic [PW-1:0] slot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hd  <= '0;
      tl  <= '0;
      occ <= '0;
    end else begin
      if (push) tl <= tl + PW'(1);
      if (pop) hd <= hd + PW'(1);
      occ <= occ + (PW+1)'(push)
                 - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent[tl] <= push_entry;
  end

  assign head  = ent[hd];
  assign empty = (occ == '0);
  assign full  = (occ == (PW+1)'(DEPTH));

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = hd + PW'(k);
      if (((PW+1)'(k) < occ) &&
          (ent[slot].idx == look_idx)) begin
        hit      = 1'b1;
        hit_data = ent[slot].data;
      end
    end
  end

endmodule

// File: rtl/store_buffered_dmem.sv
// Data memory with a FIFO store buffer drained at WLAT cycles per entry.
// Ports: clk, reset, dm (slave side of the DM_* interface).
module store_buffered_dmem
  import dmem_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int WLAT  = DEF_WLAT
) (
  input logic                 clk,
  input logic                 reset,
  store_buffered_dmem_if.slave dm
);

  localparam int CW = (WLAT > 1) ? $clog2(WLAT) : 1;
  localparam int PW = $clog2(DEPTH);

  logic [N-1:0]  mem [2**AW];

  drain_state_t  state;
  drain_state_t  state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          ovf;

  logic [AW-1:0] idx;
  sb_entry_t     push_entry;
  sb_entry_t     head;
  logic          empty;
  logic          full;
  logic [PW:0]   occ;
  logic          hit;
  logic [N-1:0]  hit_data;

  logic          tick;
  logic          last;
  logic          pop;
  logic          push;
  logic          more;
  logic          unused;

  assign idx = dm.DM_addr[AW+2:3];
  assign unused = ^{dm.DM_addr[N-1:AW+3],
                    dm.DM_addr[2:0]};

  assign push_entry.idx  = idx;
  assign push_entry.data = dm.DM_writeData;

  sb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .occ       (occ),
    .look_idx  (idx),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  // A pending head starts using the port in the
  // first cycle it is buffered, even from IDLE.
  assign tick = !dm.DM_readEnable &&
                ((state == DRAIN) || !empty);
  assign last = (cnt == CW'(WLAT-1));
  assign pop  = tick && last;
  assign push = dm.DM_writeEnable &&
                (!full || pop);
  assign more = push || (occ > (PW+1)'(1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (pop) cnt_n = '0;
    else if (tick) cnt_n = cnt + CW'(1);
    unique case (state)
      IDLE: begin
        if (!empty)
          state_n = (pop && !more) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (pop && !more) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (dm.DM_writeEnable && !push)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) mem[head.idx] <= head.data;
  end

  assign dm.DM_readData = hit ? hit_data : mem[idx];
  assign dm.sb_empty    = empty;
  assign dm.sb_full     = full;
  assign dm.sb_overflow = ovf;

endmodule

// File: tb/tb_store_buffered_dmem.sv
// Bench: three DUTs (WLAT 1/2/4) on shared stimulus vs a queue model.
// Directed scenarios followed by randomized traffic and resets.
module tb_store_buffered_dmem;

  localparam int DEPTH = 4;
  localparam int WL[3] = '{1, 2, 4};

  typedef struct {
    int          idx;
    logic [63:0] data;
  } ment_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;

  int total = 0;
  int bad = 0;

  ment_t       mq [3][$];
  logic [63:0] mmem [3][64];
  bit          mknown [3][64];
  int          mprog [3];
  bit          movf [3];

  logic [63:0] rdv [3];
  logic [63:0] rdc [3];
  logic        ev [3];
  logic        fv [3];
  logic        ov [3];

  always #5 clk = ~clk;

  store_buffered_dmem_if #(.N(64)) if1 ();
  store_buffered_dmem_if #(.N(64)) if2 ();
  store_buffered_dmem_if #(.N(64)) if4 ();

  assign if1.DM_addr        = addr;
  assign if1.DM_writeData   = wdata;
  assign if1.DM_writeEnable = we;
  assign if1.DM_readEnable  = re;
  assign if2.DM_addr        = addr;
  assign if2.DM_writeData   = wdata;
  assign if2.DM_writeEnable = we;
  assign if2.DM_readEnable  = re;
  assign if4.DM_addr        = addr;
  assign if4.DM_writeData   = wdata;
  assign if4.DM_writeEnable = we;
  assign if4.DM_readEnable  = re;

  assign rdv[0] = if1.DM_readData;
  assign rdv[1] = if2.DM_readData;
  assign rdv[2] = if4.DM_readData;
  assign ev[0]  = if1.sb_empty;
  assign ev[1]  = if2.sb_empty;
  assign ev[2]  = if4.sb_empty;
  assign fv[0]  = if1.sb_full;
  assign fv[1]  = if2.sb_full;
  assign fv[2]  = if4.sb_full;
  assign ov[0]  = if1.sb_overflow;
  assign ov[1]  = if2.sb_overflow;
  assign ov[2]  = if4.sb_overflow;

  store_buffered_dmem #(.DEPTH(DEPTH), .WLAT(1)) u1 (
    .clk(clk), .reset(reset), .dm(if1)
  );
  store_buffered_dmem #(.DEPTH(DEPTH), .WLAT(2)) u2 (
    .clk(clk), .reset(reset), .dm(if2)
  );
  store_buffered_dmem #(.DEPTH(DEPTH), .WLAT(4)) u4 (
    .clk(clk), .reset(reset), .dm(if4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit mexp(input int k, input int idx,
                              output logic [63:0] v);
    v = '0;
    for (int i = mq[k].size() - 1; i >= 0; i--)
      if (mq[k][i].idx == idx) begin
        v = mq[k][i].data;
        return 1'b1;
      end
    if (mknown[k][idx]) begin
      v = mmem[k][idx];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_flags();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("empty_w%0d", WL[k]),
          64'(ev[k]), 64'(mq[k].size() == 0));
      chk($sformatf("full_w%0d", WL[k]),
          64'(fv[k]), 64'(mq[k].size() == DEPTH));
      chk($sformatf("ovf_w%0d", WL[k]),
          64'(ov[k]), 64'(movf[k]));
    end
  endtask

  task automatic check_all();
    logic [63:0] v;
    int idx;
    idx = int'(addr[8:3]);
    for (int k = 0; k < 3; k++) begin
      rdc[k] = rdv[k];
      if (mexp(k, idx, v))
        chk($sformatf("rd_w%0d", WL[k]), rdv[k], v);
    end
    check_flags();
  endtask

  // Each buffered entry needs WLAT load-free cycles at the head.
  task automatic model_step();
    int idx;
    int occ;
    bit commit;
    ment_t e;
    idx = int'(addr[8:3]);
    for (int k = 0; k < 3; k++) begin
      occ = mq[k].size();
      commit = 1'b0;
      if (occ > 0 && !re) begin
        mprog[k]++;
        if (mprog[k] == WL[k]) begin
          commit = 1'b1;
          e = mq[k].pop_front();
          mmem[k][e.idx] = e.data;
          mknown[k][e.idx] = 1'b1;
          mprog[k] = 0;
        end
      end
      if (we) begin
        if (occ < DEPTH || commit) begin
          e.idx = idx;
          e.data = wdata;
          mq[k].push_back(e);
        end else begin
          movf[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic [63:0] a,
                     input logic [63:0] d,
                     input logic w, input logic r);
    @(negedge clk);
    addr = a;
    wdata = d;
    we = w;
    re = r;
    #1;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(addr, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mprog[k] = 0;
      movf[k] = 1'b0;
    end
    check_flags();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [63:0] ra;
  logic [63:0] rd;

  initial begin
    for (int k = 0; k < 3; k++) begin
      mprog[k] = 0;
      movf[k] = 1'b0;
      for (int i = 0; i < 64; i++) begin
        mmem[k][i] = '0;
        mknown[k][i] = 1'b0;
      end
    end
    do_reset();

    cyc(64'h10, 64'hAA, 1'b1, 1'b0);
    idle(8);
    do_reset();
    cyc(64'h10, '0, 1'b0, 1'b1);
    chk("rst_rd", rdc[1], 64'hAA);
    chk("rst_empty", 64'(ev[1]), 64'd1);

    cyc(64'h20, '0, 1'b1, 1'b0);
    idle(8);
    cyc(64'h20, 64'hDEADBEEF, 1'b1, 1'b0);
    cyc(64'h20, '0, 1'b0, 1'b0);
    chk("w2_mem_c2", u2.mem[4], 64'h0);
    cyc(64'h20, '0, 1'b0, 1'b0);
    chk("w2_mem_c3", u2.mem[4], 64'hDEADBEEF);
    chk("w2_empty_c3", 64'(ev[1]), 64'd1);

    cyc(64'h20, 64'h11, 1'b1, 1'b0);
    cyc(64'h20, '0, 1'b0, 1'b1);
    chk("fwd_c1", rdc[1], 64'h11);
    idle(8);

    cyc(64'h40, 64'd1, 1'b1, 1'b0);
    cyc(64'h40, 64'd2, 1'b1, 1'b0);
    cyc(64'h40, '0, 1'b0, 1'b1);
    chk("youngest", rdc[2], 64'd2);
    idle(12);

    for (int i = 0; i < 6; i++) begin
      cyc(64'(8 * (8 + i)), 64'(100 + i), 1'b1, 1'b0);
      if (i == 3) chk("full_c4", 64'(fv[2]), 64'd1);
      if (i == 4) chk("noovf_c5", 64'(ov[2]), 64'd0);
    end
    chk("ovf_c6", 64'(ov[2]), 64'd1);
    idle(24);
    chk("ovf_sticky", 64'(ov[2]), 64'd1);
    do_reset();

    cyc(64'h08, 64'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(64'h08, '0, 1'b0, 1'b1);
      chk("ld_blk", rdc[0], 64'd7);
    end
    chk("blk_pending", 64'(ev[0]), 64'd0);
    cyc(64'h08, '0, 1'b0, 1'b0);
    chk("blk_commit", u1.mem[1], 64'd7);
    chk("blk_empty", 64'(ev[0]), 64'd1);

    for (int i = 0; i < 3; i++)
      cyc(64'h80 + 64'(8 * i), 64'h50 + 64'(i), 1'b1, 1'b0);
    idle(16);
    for (int i = 0; i < 3; i++)
      cyc(64'h80 + 64'(8 * i), 64'h60 + 64'(i), 1'b1, 1'b0);
    do_reset();
    cyc(64'h80, '0, 1'b0, 1'b1);
    chk("mid_keep", rdc[1], 64'h60);
    cyc(64'h88, '0, 1'b0, 1'b1);
    chk("mid_old1", rdc[1], 64'h51);
    cyc(64'h90, '0, 1'b0, 1'b1);
    chk("mid_old2", rdc[1], 64'h52);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      ra = {$urandom, $urandom};
      ra[8:3] = 6'($urandom_range(0, 7));
      rd = {$urandom, $urandom};
      cyc(ra, rd, 1'($urandom_range(0, 1)),
          $urandom_range(0, 9) < 3);
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffered_dmem.md
# store_buffered_dmem

Data-memory responder that sits on the pipeline's DM_* port and serves the MEM stage's loads and stores. Stores are queued in a small FIFO store buffer and drained into a single-port word array. The drain models a write latency of WLAT cycles per entry. Loads are answered combinationally in the same cycle, with store-to-load forwarding from the buffer, so the MEM/WB register captures DM_readData unchanged.

## Interface
Parameters:
- N, 64, data and address width.
- AW, 6, word-index width; the array holds 2^AW words of N bits.
- DEPTH, 4, store-buffer entries; must be a power of 2 and at least 2.
- WLAT, 2, cycles one entry occupies the array port before it commits; must be at least 1.

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1, clock; all state changes on the rising edge.
- reset, in, 1, asynchronous active-high reset.
- DM_addr, in, N, byte address; word index = DM_addr[AW+2:3]; bits [2:0] and above AW+2 ignored.
- DM_writeData, in, N, store data.
- DM_writeEnable, in, 1, store request for this cycle.
- DM_readEnable, in, 1, load request for this cycle.
- DM_readData, out, N, load data, combinational.
- sb_empty, out, 1, buffer occupancy is 0.
- sb_full, out, 1, buffer occupancy equals DEPTH.
- sb_overflow, out, 1, sticky flag: a store was dropped.

## Operation
- **Enqueue.** When DM_writeEnable=1, {word index, data} is written at the tail.
  - Accepted if the buffer is not full, or if it is full and the head commits in the same cycle.
  - Otherwise the store is dropped and sb_overflow is set; it stays set until reset.
- **Drain FSM.** Two states, IDLE and DRAIN, with counter cnt (0..WLAT-1).
  - IDLE -> DRAIN when occupancy > 0. An entry enqueued this cycle becomes eligible next cycle.
  - In DRAIN, on each cycle with DM_readEnable=0:
    - If cnt == WLAT-1: commit the head to the array, pop it, set cnt=0, and stay in DRAIN if entries remain, else return to IDLE.
    - Otherwise cnt++.
  - A cycle with DM_readEnable=1 holds cnt, because the load owns the port.
- **Load.** DM_readData is the youngest buffer entry whose index matches, otherwise array[index].
  - A store enqueued in the same cycle is not visible to that load; the load sees the pre-store value.
  - With DM_readEnable=0, DM_readData still shows the lookup value; the consumer ignores it.
- **Simultaneous read and write.** The load is served as above and the store is enqueued.
- **Simultaneous enqueue and pop.** Occupancy is unchanged; pointers wrap modulo DEPTH.
- **Reset** (asynchronous, may arrive mid-drain):
  - Pointers, occupancy, cnt and sb_overflow go to 0; the FSM goes to IDLE.
  - Pending stores are discarded.
  - Array contents are not reset.

## Timing
- Output values at reset: sb_empty=1, sb_full=0, sb_overflow=0. DM_readData = array[index], i.e. prior or undefined contents.
- Load latency: 0 cycles, combinational from DM_addr.
- Minimum store-to-array latency: an entry enqueued in cycle t commits at the end of cycle t+WLAT, with no loads and an empty buffer ahead of it.
- From the first cycle after enqueue, forwarding covers the store until the edge at which it commits. The following cycle it is read from the array.
- Status flags are registered-state functions; they update on the edge after enqueue or pop.

## Structure
- Package dmem_pkg:
  - Default constants for N, AW, DEPTH and WLAT.
  - typedef sb_entry_t {logic [AW-1:0] idx; logic [N-1:0] data;}.
  - enum drain_state_t {IDLE, DRAIN}.
- Sub-module sb_fifo:
  - Contains the DEPTH entry registers, head and tail pointers and occupancy.
  - Exposes the head entry, a push/pop interface, and a youngest-match lookup port.
- Top level: the array, the drain FSM and counter, the overflow flag and the read mux.

## Test plan
- **Reset values.** Backdoor-load array[2]=0xAA, assert reset, read addr 0x10 -> DM_readData=0xAA, sb_empty=1, sb_full=0, sb_overflow=0.
- **Forwarding then commit.** WLAT=2. Store 0xDEADBEEF to 0x20 in cycle 0, then no loads.
  - Check: backdoor array[4] unchanged in cycle 2; equal to 0xDEADBEEF at cycle 3; sb_empty=1 at cycle 3.
  - Separate run: a load of 0x20 in cycle 1 returns 0xDEADBEEF.
- **Youngest match.** Store 1 then 2 to 0x40 in cycles 0 and 1 (WLAT=4). Load 0x40 in cycle 2 -> 2.
- **Fill and overflow.** WLAT=4, DEPTH=4, stores on cycles 0-5 with no loads.
  - sb_full=1 in cycle 4; the cycle-4 store is accepted because the head commits that cycle.
  - The cycle-5 store is dropped and sb_overflow=1 from cycle 6 onward.
- **Load blocks drain.** WLAT=1. Store 7 to 0x08 in cycle 0, DM_readEnable=1 for cycles 1-3.
  - Loads of 0x08 return 7 from the buffer.
  - Commit at the end of cycle 4; sb_empty=1 at cycle 5.
- **Reset mid-drain.** Three stores are queued and one has committed; reset is asserted asynchronously.
  - Buffer empty and sb_overflow=0.
  - The committed word is retained; the uncommitted addresses return their old array values.
